scan_test_ctrl: RTL and testbench

SCAN_TEST_CTRL -- requirements
Module: scan_test_ctrl

---
 rtl/scan_test_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_scan_test_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_test_ctrl.sv
// scan_test_ctrl -- sequencer for a single scan chain test session.
// Loads num_pat patterns through the chain, pulses one capture clock after
// each load, and compares the bits shifted out of the chain against the
// expected stream, keeping a saturating mismatch count.
// Optional diagnostics (first mismatch location, any-fail flag) are built
// only when the macro SCAN_DIAG_EN is defined.
module scan_test_ctrl #(
    parameter int  CHAIN_LEN = 16,
    parameter int  PAT_W     = 8,
    parameter int  ERR_W     = 16,
    localparam int BIT_W     = $clog2(CHAIN_LEN)
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] num_pat,
    input  logic             pat_valid,
    output logic             pat_ready,
    input  logic             si_bit,
    input  logic             exp_bit,
    input  logic             scan_out,
    output logic             scan_en,
    output logic             chain_ce,
    output logic             scan_in,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] fail_cnt,
`ifdef SCAN_DIAG_EN
    output logic [PAT_W-1:0] first_fail_pat,
    output logic [BIT_W-1:0] first_fail_bit,
    output logic             any_fail,
`endif
    output logic [2:0]       dbg_state
);

    // Bit-pair handshake: pat_ready depends only on the current state (high in
    // SHIFT and UNLOAD); a transfer happens in any cycle where pat_valid and
    // pat_ready are both high, and exactly one si_bit/exp_bit pair is consumed
    // at the following rising edge. pat_valid may be dropped at any time.

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_UNLOAD  = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    state_e           state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [PAT_W-1:0] pat_cnt_q, pat_cnt_d;
    logic [PAT_W-1:0] num_pat_q, num_pat_d;
    logic [ERR_W-1:0] fail_cnt_q, fail_cnt_d;

    logic start_acc;
    logic abort_hit;
    logic xfer;
    logic cmp_en;
    logic mis_evt;

    // A start only opens a session from IDLE with a non-zero pattern count.
    assign start_acc = (state_q == ST_IDLE) && start && (num_pat != '0);
    // Abort is meaningful only while a session (or its DONE beat) is running.
    assign abort_hit = abort && (state_q != ST_IDLE);
    // One bit pair moves through the chain in this cycle.
    assign xfer      = pat_valid && ((state_q == ST_SHIFT) || (state_q == ST_UNLOAD));
    // The first load finds no captured response in the chain, so skip it.
    assign cmp_en    = xfer && ((state_q == ST_UNLOAD) || (pat_cnt_q != '0));
    // A counted mismatch; an aborting cycle never updates the result.
    assign mis_evt   = cmp_en && (scan_out ^ exp_bit) && !abort_hit;

    // Next-state, counter updates and chain control outputs.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        pat_cnt_d  = pat_cnt_q;
        num_pat_d  = num_pat_q;
        fail_cnt_d = fail_cnt_q;
        pat_ready  = 1'b0;
        scan_en    = 1'b0;
        chain_ce   = 1'b0;
        scan_in    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (start_acc) begin
                        state_d    = ST_SHIFT;
                        num_pat_d  = num_pat;
                        fail_cnt_d = '0;
                        bit_cnt_d  = '0;
                        pat_cnt_d  = '0;
                    end else begin
                        // Empty session: report completion straight away.
                        state_d = ST_DONE;
                    end
                end
            end

            ST_SHIFT: begin
                busy      = 1'b1;
                pat_ready = 1'b1;
                scan_en   = 1'b1;
                chain_ce  = xfer;
                scan_in   = xfer && si_bit;
                if (xfer) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = ST_CAPTURE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end

            ST_CAPTURE: begin
                busy      = 1'b1;
                chain_ce  = 1'b1;
                pat_cnt_d = pat_cnt_q + PAT_W'(1);
                // pat_cnt_q < num_pat_q always holds here, so no overflow.
                if (pat_cnt_d < num_pat_q) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_UNLOAD;
                end
            end

            ST_UNLOAD: begin
                busy      = 1'b1;
                pat_ready = 1'b1;
                scan_en   = 1'b1;
                chain_ce  = xfer;
                if (xfer) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end

            ST_DONE: begin
                done      = 1'b1;
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                pat_cnt_d = '0;
            end

            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                pat_cnt_d = '0;
            end
        endcase

        if (mis_evt && (fail_cnt_q != ERR_MAX)) begin
            fail_cnt_d = fail_cnt_q + ERR_W'(1);
        end

        // Abort wins over every transition; the result register is frozen.
        if (abort_hit) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = '0;
            pat_cnt_d  = '0;
            fail_cnt_d = fail_cnt_q;
        end
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            pat_cnt_q  <= '0;
            num_pat_q  <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            pat_cnt_q  <= pat_cnt_d;
            num_pat_q  <= num_pat_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign fail_cnt  = fail_cnt_q;
    assign dbg_state = state_q;

`ifdef SCAN_DIAG_EN
    logic [PAT_W-1:0] ff_pat_q, ff_pat_d;
    logic [BIT_W-1:0] ff_bit_q, ff_bit_d;
    logic             any_fail_q, any_fail_d;

    // Latch the location of the first mismatch after an accepted start.
    // The response unloaded during a load (or the final unload) belongs to
    // the previously captured pattern, hence pat_cnt_q - 1.
    always_comb begin
        ff_pat_d   = ff_pat_q;
        ff_bit_d   = ff_bit_q;
        any_fail_d = any_fail_q;
        if (start_acc) begin
            ff_pat_d   = '0;
            ff_bit_d   = '0;
            any_fail_d = 1'b0;
        end else if (mis_evt && !any_fail_q) begin
            ff_pat_d   = pat_cnt_q - PAT_W'(1);
            ff_bit_d   = bit_cnt_q;
            any_fail_d = 1'b1;
        end
    end

    // Diagnostic registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ff_pat_q   <= '0;
            ff_bit_q   <= '0;
            any_fail_q <= 1'b0;
        end else begin
            ff_pat_q   <= ff_pat_d;
            ff_bit_q   <= ff_bit_d;
            any_fail_q <= any_fail_d;
        end
    end

    assign first_fail_pat = ff_pat_q;
    assign first_fail_bit = ff_bit_q;
    assign any_fail       = any_fail_q;
`endif

endmodule

// File: tb/tb_scan_test_ctrl.sv
// tb_scan_test_ctrl -- randomized scoreboard bench for scan_test_ctrl.
// A behavioural scan chain (shift register plus a fixed capture function)
// sits on the DUT's chain pins. Expected unload bits, completion latency and
// mismatch counts are derived from the generated patterns arithmetically.
module tb_scan_test_ctrl;

    localparam int L      = 16;
    localparam int PW     = 8;
    localparam int EW     = 2;
    localparam int BW     = $clog2(L);
    localparam int SAT    = (1 << EW) - 1;
    localparam int BUDGET = 4000;

    typedef struct packed {
        logic [15:0]   lat;
        logic [EW-1:0] fail;
        logic [PW-1:0] fpat;
        logic [BW-1:0] fbit;
        logic          anyf;
    } exp_t;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic [PW-1:0] num_pat   = '0;
    logic          pat_valid = 1'b0;
    logic          si_bit    = 1'b0;
    logic          exp_bit   = 1'b0;
    logic          scan_out;
    logic          pat_ready, scan_en, chain_ce, scan_in, busy, done;
    logic [EW-1:0] fail_cnt;
    logic [2:0]    dbg_state;
`ifdef SCAN_DIAG_EN
    logic [PW-1:0] first_fail_pat;
    logic [BW-1:0] first_fail_bit;
    logic          any_fail;
`endif

    int   total     = 0;
    int   bad       = 0;
    int   cyc       = 0;
    int   start_cyc = 0;
    int   done_cnt  = 0;
    exp_t exp_q[$];
    logic [L-1:0] chain = '0;

    scan_test_ctrl #(.CHAIN_LEN(L), .PAT_W(PW), .ERR_W(EW)) dut (
        .CLK       (clk),
        .RSTN      (rst_n),
        .start     (start),
        .abort     (abort),
        .num_pat   (num_pat),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .si_bit    (si_bit),
        .exp_bit   (exp_bit),
        .scan_out  (scan_out),
        .scan_en   (scan_en),
        .chain_ce  (chain_ce),
        .scan_in   (scan_in),
        .busy      (busy),
        .done      (done),
        .fail_cnt  (fail_cnt),
`ifdef SCAN_DIAG_EN
        .first_fail_pat (first_fail_pat),
        .first_fail_bit (first_fail_bit),
        .any_fail       (any_fail),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, state=%0d", dbg_state);
        $fatal(1, "watchdog");
    end

    // ---------------- scan chain model ----------------
    // What the chain's combinational cloud would present at capture.
    function automatic logic [L-1:0] capture_fn(input logic [L-1:0] c);
        logic [L-1:0] r;
        for (int j = 0; j < L; j++) r[j] = c[j] ^ c[(j + 1) % L] ^ ((j % 2) == 1);
        return r;
    endfunction

    assign scan_out = chain[L-1];

    always @(posedge clk) begin
        if (chain_ce === 1'b1) begin
            if (scan_en === 1'b1) chain <= {chain[L-2:0], scan_in};
            else                  chain <= capture_fn(chain);
        end
    end

    // ---------------- checking ----------------
    function automatic void check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endfunction

    // Scoreboard monitor: every done pulse retires one expected session.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("done_latency", cyc - start_cyc, int'(e.lat));
                check("fail_cnt", int'(fail_cnt), int'(e.fail));
`ifdef SCAN_DIAG_EN
                check("diag_any_fail", int'(any_fail), int'(e.anyf));
                if (e.anyf) begin
                    check("diag_first_pat", int'(first_fail_pat), int'(e.fpat));
                    check("diag_first_bit", int'(first_fail_bit), int'(e.fbit));
                end
`endif
            end
            done_cnt++;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      int'(busy),      0);
        check({tag, "_done"},      int'(done),      0);
        check({tag, "_pat_ready"}, int'(pat_ready), 0);
        check({tag, "_scan_en"},   int'(scan_en),   0);
        check({tag, "_chain_ce"},  int'(chain_ce),  0);
        check({tag, "_scan_in"},   int'(scan_in),   0);
        check({tag, "_fail_cnt"},  int'(fail_cnt),  0);
    endtask

    // ---------------- driver ----------------
    // np patterns; nflip random mismatches plus an optional forced one;
    // abort_at / rst_at / stall5_at are transfer indices (-1 = unused).
    task automatic run_session(input int np, input int nflip, input int force_flip,
                               input int abort_at, input int rst_at,
                               input int stall5_at, input bit rnd_stall);
        logic [L-1:0] pats[$];
        logic         si_a[$];
        logic         ex_a[$];
        int           stall_a[$];
        bit           flip_a[$];
        logic [L-1:0] resp;
        exp_t         e;
        int n_x, lim, cnt, first, stall_sum, t, left, guard, d0, w, pick;
        bit stop;

        n_x = (np == 0) ? 0 : np * L + L;
        for (int p = 0; p < np; p++) pats.push_back(L'($urandom));
        for (int i = 0; i < n_x; i++) begin
            int p;
            int k;
            p = i / L;
            k = i % L;
            if (p < np) si_a.push_back(pats[p][L-1-k]);
            else        si_a.push_back(1'($urandom));
            if (p == 0) begin
                ex_a.push_back(1'($urandom));
            end else begin
                resp = capture_fn(pats[p-1]);
                ex_a.push_back(resp[L-1-k]);
            end
            flip_a.push_back(1'b0);
            stall_a.push_back((rnd_stall && $urandom_range(0, 7) == 0) ?
                              int'($urandom_range(1, 2)) : 0);
        end
        if (stall5_at >= 0) stall_a[stall5_at] = 5;
        if (force_flip >= 0) flip_a[force_flip] = 1'b1;
        for (int f = 0; f < nflip; f++) begin
            pick = int'($urandom_range(L, n_x - 1));
            while (flip_a[pick]) pick = (pick + 1 < n_x) ? pick + 1 : L;
            flip_a[pick] = 1'b1;
        end

        lim = (abort_at >= 0) ? abort_at : n_x;
        cnt = 0;
        first = -1;
        stall_sum = 0;
        for (int i = 0; i < n_x; i++) begin
            if (flip_a[i]) begin
                ex_a[i] = ~ex_a[i];
                if (i < lim) begin
                    cnt++;
                    if (first < 0) first = i;
                end
            end
            stall_sum += stall_a[i];
        end
        e.lat  = 16'((np == 0) ? 1 : np * (L + 1) + L + 1 + stall_sum);
        e.fail = EW'((cnt > SAT) ? SAT : cnt);
        e.anyf = (cnt > 0);
        e.fpat = (first >= 0) ? PW'(first / L - 1) : '0;
        e.fbit = (first >= 0) ? BW'(first % L) : '0;
        if (abort_at < 0 && rst_at < 0) exp_q.push_back(e);

        d0 = done_cnt;
        @(negedge clk);
        num_pat   = PW'(np);
        start     = 1'b1;
        abort     = 1'b0;
        start_cyc = cyc;
        pat_valid = 1'($urandom);
        if (np == 0) begin
            #1;
            check("np0_busy_c0", int'(busy), 0);
        end
        @(negedge clk);
        start = 1'b0;

        t = 0;
        guard = 0;
        stop = 1'b0;
        left = (n_x > 0) ? stall_a[0] : 0;
        while (t < n_x && !stop && guard < BUDGET) begin
            guard++;
            start   = ($urandom_range(0, 9) == 0);
            num_pat = PW'($urandom);
            if (t == abort_at && pat_ready) begin
                start     = 1'b0;
                abort     = 1'b1;
                stop      = 1'b1;
                pat_valid = 1'b1;
                si_bit    = si_a[t];
                exp_bit   = ~ex_a[t];
            end else if (t == rst_at && pat_ready) begin
                start     = 1'b0;
                pat_valid = 1'b0;
                rst_n     = 1'b0;
                stop      = 1'b1;
                #1;
                check_all_zero("rst_mid");
            end else if (pat_ready) begin
                if (left > 0) begin
                    pat_valid = 1'b0;
                    si_bit    = 1'($urandom);
                    exp_bit   = 1'($urandom);
                    left--;
                    #1;
                    check("stall_chain_ce", int'(chain_ce), 0);
                end else begin
                    pat_valid = 1'b1;
                    si_bit    = si_a[t];
                    exp_bit   = ex_a[t];
                    #1;
                    check("xfer_chain_ce", int'(chain_ce), 1);
                    check("xfer_scan_in", int'(scan_in), (t < np * L) ? int'(si_a[t]) : 0);
                    t++;
                    if (t < n_x) left = stall_a[t];
                end
            end else begin
                pat_valid = 1'($urandom);
                si_bit    = 1'($urandom);
                exp_bit   = 1'($urandom);
            end
            @(negedge clk);
        end
        start     = 1'b0;
        pat_valid = 1'b0;
        num_pat   = '0;
        if (!stop) check("xfer_count", t, n_x);

        if (abort_at >= 0) begin
            abort = 1'b0;
            #1;
            check("abort_busy", int'(busy), 0);
            check("abort_pat_ready", int'(pat_ready), 0);
            check("abort_done", int'(done), 0);
            check("abort_fail_hold", int'(fail_cnt), int'(e.fail));
            repeat (30) @(negedge clk);
            #1;
            check("abort_stays_idle", int'(busy), 0);
            check("abort_no_done", done_cnt - d0, 0);
        end else if (rst_at >= 0) begin
            rst_n = 1'b1;
            @(negedge clk);
            #1;
            check("rst_rel_busy", int'(busy), 0);
            check("rst_rel_fail", int'(fail_cnt), 0);
            check("rst_no_done", done_cnt - d0, 0);
        end else begin
            #2;
            w = 0;
            while (done_cnt == d0 && w < 200) begin
                @(negedge clk);
                #2;
                w++;
            end
            check("done_seen", done_cnt - d0, 1);
            if (np == 0) begin
                check("np0_busy", int'(busy), 0);
                check("np0_chain_ce", int'(chain_ce), 0);
            end
            @(negedge clk);
            #1;
            check("done_one_cycle", int'(done), 0);
            check("fail_hold", int'(fail_cnt), int'(e.fail));
            check("idle_busy", int'(busy), 0);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_reset_busy", int'(busy), 0);

        run_session(0, 0, -1, -1, -1, -1, 1'b0);          // empty session
        run_session(1, 0, -1, -1, -1, -1, 1'b0);          // baseline, 34 cycles
        run_session(3, 0, 2 * L + 9, -1, -1, -1, 1'b0);   // flip in second response
        run_session(2, 0, -1, -1, -1, 5, 1'b0);           // 5-cycle stall mid-shift
        run_session(3, 0, L + 3, L + 7, -1, -1, 1'b0);    // abort in pattern 2
        run_session(1, 0, -1, -1, -1, -1, 1'b0);          // clean run after abort
        run_session(2, 2, -1, -1, 2 * L + 5, -1, 1'b0);   // reset during unload
        run_session(2, 5, -1, -1, -1, -1, 1'b0);          // counter saturation
        for (int r = 0; r < 10; r++) begin
            run_session(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                        -1, -1, -1, -1, 1'b1);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
